// File: rtl/dm9000a_access_sequencer_if.sv
// Request/response channel between a command source (init FSM, packet engine)
// and the DM9000A access sequencer.
interface dm9000a_access_sequencer_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [7:0]  req_idx_i;
    logic [15:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [15:0] rsp_rdata_o;
    logic        busy_o;

    modport master (
        output req_valid_i, req_we_i, req_idx_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_idx_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o
    );
endinterface

// File: rtl/dm9000a_access_sequencer.sv
// DM9000A register access sequencer: index phase then data phase with programmable
// setup/pulse/hold/recovery. Optional index cache: define DM9000A_IDX_CACHE_EN.
module dm9000a_access_sequencer #(
    parameter int unsigned T_SETUP = 1,
    parameter int unsigned T_PULSE = 3,
    parameter int unsigned T_HOLD  = 1,
    parameter int unsigned T_RECOV = 2
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_n_i,
    dm9000a_access_sequencer_if.slave      req,
    output logic                           oENET_CMD,
    output logic                           oENET_CS_N,
    output logic                           oENET_IOR_N,
    output logic                           oENET_IOW_N,
    output logic [15:0]                    ENET_D_o,
    output logic                           ENET_D_oe,
    input  logic [15:0]                    ENET_D_i
);

    localparam int unsigned TS = (T_SETUP == 0) ? 1 : T_SETUP;
    localparam int unsigned TP = (T_PULSE == 0) ? 1 : T_PULSE;
    localparam int unsigned TH = (T_HOLD  == 0) ? 1 : T_HOLD;
    localparam int unsigned TR = (T_RECOV == 0) ? 1 : T_RECOV;
    localparam int unsigned CW = 16;
    localparam logic HAS_D_RECOV = (TR > 1);

    typedef enum logic [3:0] {
        IDLE, I_SETUP, I_PULSE, I_HOLD, I_RECOV,
        D_SETUP, D_PULSE, D_HOLD, D_RECOV
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_done;
    logic          we_q, we_d;
    logic [7:0]    idx_q, idx_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          skip_index;
    logic          rsp_valid_q;
    logic [15:0]   rsp_rdata_q;

    logic          cmd_d, cs_n_d, ior_n_d, iow_n_d, oe_d;
    logic [15:0]   dout_d;

    // The IDLE cycle is the final data-phase recovery cycle, so D_RECOV runs
    // TR-1 cycles and a waiting request is accepted with no extra gap.
    function automatic logic [CW-1:0] reload(input state_t s);
        case (s)
            I_SETUP, D_SETUP: reload = CW'(TS - 1);
            I_PULSE, D_PULSE: reload = CW'(TP - 1);
            I_HOLD,  D_HOLD:  reload = CW'(TH - 1);
            I_RECOV:          reload = CW'(TR - 1);
            D_RECOV:          reload = CW'(TR - 2);
            default:          reload = '0;
        endcase
    endfunction

    assign cnt_done = (cnt_q == '0);

`ifdef DM9000A_IDX_CACHE_EN
    logic [7:0] cache_idx_q;
    logic       cache_vld_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cache_idx_q <= '0;
            cache_vld_q <= 1'b0;
        end else if (state_q == I_HOLD && cnt_done) begin
            cache_idx_q <= idx_q;
            cache_vld_q <= 1'b1;
        end
    end

    assign skip_index = cache_vld_q && (req.req_idx_i == cache_idx_q);
`else
    assign skip_index = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (req.req_valid_i) begin
                we_d    = req.req_we_i;
                idx_d   = req.req_idx_i;
                wdata_d = req.req_wdata_i;
                state_d = skip_index ? D_SETUP : I_SETUP;
            end
            I_SETUP: if (cnt_done) state_d = I_PULSE;
            I_PULSE: if (cnt_done) state_d = I_HOLD;
            I_HOLD:  if (cnt_done) state_d = I_RECOV;
            I_RECOV: if (cnt_done) state_d = D_SETUP;
            D_SETUP: if (cnt_done) state_d = D_PULSE;
            D_PULSE: if (cnt_done) state_d = D_HOLD;
            D_HOLD:  if (cnt_done) state_d = HAS_D_RECOV ? D_RECOV : IDLE;
            D_RECOV: if (cnt_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = reload(state_d);
        else if (!cnt_done)     cnt_d = cnt_q - CW'(1);
    end

    // Pins are decoded from the next state and registered alongside it.
    always_comb begin
        cmd_d   = oENET_CMD;
        cs_n_d  = 1'b1;
        ior_n_d = 1'b1;
        iow_n_d = 1'b1;
        oe_d    = 1'b0;
        dout_d  = ENET_D_o;
        case (state_d)
            I_SETUP, I_PULSE, I_HOLD: begin
                cmd_d   = 1'b0;
                cs_n_d  = 1'b0;
                oe_d    = 1'b1;
                dout_d  = {8'h00, idx_d};
                iow_n_d = (state_d != I_PULSE);
            end
            D_SETUP, D_PULSE, D_HOLD: begin
                cmd_d  = 1'b1;
                cs_n_d = 1'b0;
                if (we_d) begin
                    oe_d    = 1'b1;
                    dout_d  = wdata_d;
                    iow_n_d = (state_d != D_PULSE);
                end else begin
                    ior_n_d = (state_d != D_PULSE);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            oENET_CMD   <= 1'b0;
            oENET_CS_N  <= 1'b1;
            oENET_IOR_N <= 1'b1;
            oENET_IOW_N <= 1'b1;
            ENET_D_o    <= '0;
            ENET_D_oe   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            oENET_CMD   <= cmd_d;
            oENET_CS_N  <= cs_n_d;
            oENET_IOR_N <= ior_n_d;
            oENET_IOW_N <= iow_n_d;
            ENET_D_o    <= dout_d;
            ENET_D_oe   <= oe_d;
            if (state_q == D_PULSE && cnt_done && !we_q) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= ENET_D_i;
            end else begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign req.req_ready_o = (state_q == IDLE);
    assign req.busy_o      = (state_q != IDLE);
    assign req.rsp_valid_o = rsp_valid_q;
    assign req.rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dm9000a_access_sequencer.sv
// Bench for dm9000a_access_sequencer: chip-side register model, read scoreboard,
// strobe/timing monitors, default-timing DUT plus a minimum-timing DUT.
module tb_dm9000a_access_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm9000a_access_sequencer_if ifa ();
    dm9000a_access_sequencer_if ifb ();

    logic        cmd_a, cs_a, ior_a, iow_a, oe_a;
    logic [15:0] do_a, di_a;
    logic        cmd_b, cs_b, ior_b, iow_b, oe_b;
    logic [15:0] do_b, di_b;

    dm9000a_access_sequencer u_dut_a (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .req(ifa),
        .oENET_CMD(cmd_a), .oENET_CS_N(cs_a), .oENET_IOR_N(ior_a), .oENET_IOW_N(iow_a),
        .ENET_D_o(do_a), .ENET_D_oe(oe_a), .ENET_D_i(di_a)
    );

    dm9000a_access_sequencer #(.T_PULSE(0), .T_RECOV(0)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .req(ifb),
        .oENET_CMD(cmd_b), .oENET_CS_N(cs_b), .oENET_IOR_N(ior_b), .oENET_IOW_N(iow_b),
        .ENET_D_o(do_b), .ENET_D_oe(oe_b), .ENET_D_i(di_b)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Chip register model driven purely from the pins.
    function automatic logic [15:0] preload(input int unsigned i);
        logic [7:0] b;
        b = 8'(i);
        preload = (b == 8'h28) ? 16'h0A46 : {8'hC3, b};
    endfunction

    logic [15:0] chip_mem [256];
    logic [7:0]  chip_idx;

    assign di_a = (!ior_a && !cs_a) ? chip_mem[chip_idx] : 16'hDEAD;
    assign di_b = (!ior_b && !cs_b) ? 16'h1357 : 16'hDEAD;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) chip_mem[i] <= preload(32'(i));
            chip_idx <= 8'h00;
        end else if (!iow_a && !cs_a) begin
            if (!cmd_a) chip_idx <= do_a[7:0];
            else        chip_mem[chip_idx] <= do_a;
        end
    end

    // Strobe monitors.
    int unsigned iow_w_a = 0, ior_w_a = 0, iow_w_b = 0, ior_w_b = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            iow_w_a = 0; ior_w_a = 0; iow_w_b = 0; ior_w_b = 0;
        end else begin
            check("strobe_overlap_a", 32'(ior_a | iow_a), 1);
            check("strobe_overlap_b", 32'(ior_b | iow_b), 1);
            if (!iow_a) begin
                iow_w_a++;
                check("iow_cs_a", 32'(cs_a), 0);
                check("iow_oe_a", 32'(oe_a), 1);
            end else if (iow_w_a != 0) begin
                check("iow_width_a", iow_w_a, 3);
                iow_w_a = 0;
            end
            if (!ior_a) begin
                ior_w_a++;
                check("ior_cs_a", 32'(cs_a), 0);
                check("ior_oe_a", 32'(oe_a), 0);
                check("ior_cmd_a", 32'(cmd_a), 1);
            end else if (ior_w_a != 0) begin
                check("ior_width_a", ior_w_a, 3);
                ior_w_a = 0;
            end
            if (!iow_b) iow_w_b++;
            else if (iow_w_b != 0) begin
                check("iow_width_b", iow_w_b, 1);
                iow_w_b = 0;
            end
            if (!ior_b) ior_w_b++;
            else if (ior_w_b != 0) begin
                check("ior_width_b", ior_w_b, 1);
                ior_w_b = 0;
            end
        end
    end

    // Read scoreboard: expectations pushed at issue, popped on rsp_valid.
    logic [15:0] exp_q [$];
    int unsigned rsp_b_cnt = 0;
    always @(negedge clk) begin
        if (rst_n && ifa.rsp_valid_o) begin
            check("rsp_expected_a", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("rsp_rdata_a", 32'(ifa.rsp_rdata_o), 32'(exp_q.pop_front()));
            check("rsp_hold_cs_a", 32'(cs_a), 0);
            check("rsp_hold_ior_a", 32'(ior_a), 1);
        end
        if (rst_n && ifb.rsp_valid_o) begin
            rsp_b_cnt++;
            check("rsp_rdata_b", 32'(ifb.rsp_rdata_o), 32'h1357);
        end
    end

    int unsigned cyc = 0;
    int unsigned acc_cyc [$];
    always @(posedge clk) begin
        if (rst_n && ifa.req_valid_i && ifa.req_ready_o) acc_cyc.push_back(cyc);
        cyc++;
    end

    // Expected access length, tracking the index cache when it is built in.
    logic       c_vld = 1'b0;
    logic [7:0] c_idx = 8'h00;
    function automatic int unsigned exp_lat(input logic [7:0] idx);
`ifdef DM9000A_IDX_CACHE_EN
        exp_lat = (c_vld && idx == c_idx) ? 7 : 14;
`else
        exp_lat = 14;
`endif
        c_vld = 1'b1;
        c_idx = idx;
    endfunction

    task automatic do_req(input logic we, input logic [7:0] idx, input logic [15:0] wd,
                          input logic [15:0] exp_rd);
        int unsigned n, lat, el;
        @(negedge clk);
        ifa.req_we_i = we; ifa.req_idx_i = idx; ifa.req_wdata_i = wd; ifa.req_valid_i = 1'b1;
        if (!we) exp_q.push_back(exp_rd);
        el = exp_lat(idx);
        n = 0;
        while (!ifa.req_ready_o && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        ifa.req_valid_i = 1'b0;
        ifa.req_idx_i = ~idx;
        check("busy_after_accept", 32'(ifa.busy_o), 1);
        lat = 1;
        while (!ifa.req_ready_o && lat < 200) begin @(negedge clk); lat++; end
        check("access_latency", lat, el);
    endtask

    task automatic do_req_b(input logic we, input logic [7:0] idx);
        int unsigned lat;
        @(negedge clk);
        ifb.req_we_i = we; ifb.req_idx_i = idx; ifb.req_wdata_i = 16'h00FF; ifb.req_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifb.req_valid_i = 1'b0;
        lat = 1;
        while (!ifb.req_ready_o && lat < 200) begin @(negedge clk); lat++; end
        check("access_latency_b", lat, 8);
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  idx;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t vecs [11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        vecs[0]  = '{1'b1, 8'h1F, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 8'h1F, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b0, 8'h28, 16'h0000, 16'h0A46};
        vecs[3]  = '{1'b1, 8'h05, 16'hABCD, 16'h0000};
        vecs[4]  = '{1'b0, 8'h05, 16'h0000, 16'hABCD};
        vecs[5]  = '{1'b1, 8'h05, 16'hFFFF, 16'h0000};
        vecs[6]  = '{1'b0, 8'h05, 16'h0000, 16'hFFFF};
        vecs[7]  = '{1'b0, 8'h05, 16'h0000, 16'hFFFF};
        vecs[8]  = '{1'b1, 8'h00, 16'h1234, 16'h0000};
        vecs[9]  = '{1'b0, 8'h00, 16'h0000, 16'h1234};
        vecs[10] = '{1'b0, 8'h7E, 16'h0000, 16'hC37E};

        ifa.req_valid_i = 1'b0; ifa.req_we_i = 1'b0; ifa.req_idx_i = '0; ifa.req_wdata_i = '0;
        ifb.req_valid_i = 1'b0; ifb.req_we_i = 1'b0; ifb.req_idx_i = '0; ifb.req_wdata_i = '0;

        #22;
        check("rst_cs_n", 32'(cs_a), 1);
        check("rst_ior_n", 32'(ior_a), 1);
        check("rst_iow_n", 32'(iow_a), 1);
        check("rst_cmd", 32'(cmd_a), 0);
        check("rst_d_oe", 32'(oe_a), 0);
        check("rst_d_o", 32'(do_a), 0);
        check("rst_rsp_valid", 32'(ifa.rsp_valid_o), 0);
        check("rst_rsp_rdata", 32'(ifa.rsp_rdata_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(ifa.req_ready_o), 1);
        check("busy_after_rst", 32'(ifa.busy_o), 0);

        foreach (vecs[i]) do_req(vecs[i].we, vecs[i].idx, vecs[i].wdata, vecs[i].exp_rd);

        // Back-to-back reads with req_valid_i held high.
        acc_cyc.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ifa.req_we_i = 1'b0; ifa.req_idx_i = 8'(8'h10 + k); ifa.req_valid_i = 1'b1;
            exp_q.push_back({8'hC3, 8'(8'h10 + k)});
            void'(exp_lat(8'(8'h10 + k)));
            n = 0;
            while (!ifa.req_ready_o && n < 200) begin @(negedge clk); n++; end
            @(posedge clk);
        end
        @(negedge clk);
        ifa.req_valid_i = 1'b0;
        n = 0;
        while (!ifa.req_ready_o && n < 200) begin @(negedge clk); n++; end
        check("b2b_accepts", 32'(acc_cyc.size()), 3);
        if (acc_cyc.size() == 3) begin
            check("b2b_gap_1", acc_cyc[1] - acc_cyc[0], 14);
            check("b2b_gap_2", acc_cyc[2] - acc_cyc[1], 14);
        end

        // Reset during the data strobe of a write.
        @(negedge clk);
        ifa.req_we_i = 1'b1; ifa.req_idx_i = 8'h70; ifa.req_wdata_i = 16'hBEEF; ifa.req_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.req_valid_i = 1'b0;
        n = 0;
        while (!(!iow_a && cmd_a) && n < 200) begin @(negedge clk); n++; end
        check("reached_d_pulse", 32'(!iow_a && cmd_a), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs_a), 1);
        check("abort_iow_n", 32'(iow_a), 1);
        check("abort_d_oe", 32'(oe_a), 0);
        check("abort_cmd", 32'(cmd_a), 0);
        c_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(ifa.req_ready_o), 1);
        check("abort_rdata_cleared", 32'(ifa.rsp_rdata_o), 0);

        // Index cache behaviour: same index twice, then a different one.
        do_req(1'b0, 8'h28, 16'h0000, 16'h0A46);
        do_req(1'b0, 8'h28, 16'h0000, 16'h0A46);
        do_req(1'b0, 8'h29, 16'h0000, 16'hC329);

        // Minimum-timing instance: zero pulse/recovery act as one cycle.
        do_req_b(1'b1, 8'h01);
        do_req_b(1'b0, 8'h02);
        check("rsp_count_b", rsp_b_cnt, 1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
